// File: rtl/led_flow_pkg.sv
// rtl/led_flow_pkg.sv - shared mode encodings, direction encodings and bar-pattern helper
// Contents:
//   MODE_ROL/MODE_ROR/MODE_PINGPONG/MODE_BAR : values of the 2-bit mode input
//   DIR_LEFT/DIR_RIGHT                       : ping-pong travel / bar fill direction
//   therm(lvl)                               : thermometer code with the lowest lvl bits set
package led_flow_pkg;

    localparam logic [1:0] MODE_ROL      = 2'd0;
    localparam logic [1:0] MODE_ROR      = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_BAR      = 2'd3;

    // DIR_LEFT means "towards the MSB" for ping-pong and "filling" for the bar
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Returned at full 32-bit width; callers truncate to their LED count
    function automatic logic [31:0] therm(input int unsigned lvl);
        if (lvl >= 32) begin
            return '1;
        end
        return (32'd1 << lvl) - 32'd1;
    endfunction

endpackage

// File: rtl/led_step_gen.sv
// rtl/led_step_gen.sv - prescaler producing the pattern step strobe
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   speed      : divides the base period by 1/2/4/8
//   run        : 1 counts, 0 holds the count
//   clr        : synchronous clear of the count, suppresses the strobe
//   step       : combinational strobe, high in the cycle whose edge advances the pattern
module led_step_gen #(
    parameter int unsigned BASE = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic       run,
    input  logic       clr,
    output logic       step
);

    localparam int unsigned CW = (BASE > 1) ? $clog2(BASE) : 1;

    logic [CW-1:0] cnt;
    logic [31:0]   span;
    logic [31:0]   term;

    always_comb begin
        span = 32'(BASE) >> speed;
        term = (span > 32'd0) ? span - 32'd1 : 32'd0;
    end

    // >= rather than == so that a speed increase mid-count fires immediately
    // instead of wrapping all the way round the counter
    assign step = run & ~clr & (32'(cnt) >= term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            if (step) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_flow_multi.sv
// rtl/led_flow_multi.sv - multi-mode LED flow-light controller (ROL, ROR, ping-pong, bar)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : 0 ROL, 1 ROR, 2 ping-pong, 3 bar fill/empty
//   speed      : step rate 1x/2x/4x/8x of STEP_MS
//   run        : 1 advance, 0 pause
//   restart    : pulse reloading the start state of the current mode
//   led        : registered pin drive, polarity set by ACTIVE_LOW
//   step_tick  : registered pulse, high in the cycle the new pattern is shown
module led_flow_multi
    import led_flow_pkg::*;
#(
    parameter int unsigned LED_W      = 4,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned STEP_MS    = 500,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             run,
    input  logic             restart,
    output logic [LED_W-1:0] led,
    output logic             step_tick
);

    localparam int unsigned      BASE = CLK_HZ / 1000 * STEP_MS;
    localparam int unsigned      LW   = $clog2(LED_W + 1);
    localparam logic [LED_W-1:0] POL  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [LED_W-1:0] LSB  = LED_W'(1);
    localparam logic [LED_W-1:0] MSB  = LSB << (LED_W - 1);
    localparam logic [LW-1:0]    LTOP = LW'(LED_W);

    logic [1:0]       mode_q;
    logic             dir, dir_n;
    logic [LW-1:0]    lvl, lvl_n;
    logic [LED_W-1:0] pat, pat_n;
    logic [LED_W-1:0] led_n;
    logic             reload;
    logic             step;

    // A mode change is handled exactly like a restart: one reload cycle
    assign reload = restart | (mode != mode_q);

    led_step_gen #(
        .BASE (BASE)
    ) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .speed (speed),
        .run   (run),
        .clr   (reload),
        .step  (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_ROL;
            dir       <= DIR_LEFT;
            lvl       <= '0;
            pat       <= LSB;
            led       <= LSB ^ POL;
            step_tick <= 1'b0;
        end else begin
            mode_q    <= mode;
            dir       <= dir_n;
            lvl       <= lvl_n;
            pat       <= pat_n;
            led       <= led_n;
            step_tick <= step;
        end
    end

    always_comb begin
        pat_n = pat;
        dir_n = dir;
        lvl_n = lvl;
        if (reload) begin
            dir_n = DIR_LEFT;
            lvl_n = '0;
            case (mode)
                MODE_ROL:      pat_n = LSB;
                MODE_ROR:      pat_n = MSB;
                MODE_PINGPONG: pat_n = LSB;
                default:       pat_n = '0;
            endcase
        end else if (step) begin
            case (mode_q)
                MODE_ROL: begin
                    // anything but one-hot (e.g. 0) would rotate forever unchanged
                    pat_n = $onehot(pat) ? {pat[LED_W-2:0], pat[LED_W-1]} : LSB;
                end
                MODE_ROR: begin
                    pat_n = $onehot(pat) ? {pat[0], pat[LED_W-1:1]} : MSB;
                end
                MODE_PINGPONG: begin
                    // turning at the end on the same step avoids a double-length dwell
                    if (!$onehot(pat)) begin
                        pat_n = LSB;
                        dir_n = DIR_LEFT;
                    end else if (dir == DIR_LEFT) begin
                        if (pat[LED_W-1]) begin
                            pat_n = pat >> 1;
                            dir_n = DIR_RIGHT;
                        end else begin
                            pat_n = pat << 1;
                        end
                    end else begin
                        if (pat[0]) begin
                            pat_n = pat << 1;
                            dir_n = DIR_LEFT;
                        end else begin
                            pat_n = pat >> 1;
                        end
                    end
                end
                default: begin
                    if (lvl > LTOP) begin
                        lvl_n = '0;
                        dir_n = DIR_LEFT;
                    end else if (dir == DIR_LEFT) begin
                        if (lvl == LTOP) begin
                            lvl_n = lvl - LW'(1);
                            dir_n = DIR_RIGHT;
                        end else begin
                            lvl_n = lvl + LW'(1);
                        end
                    end else begin
                        if (lvl == '0) begin
                            lvl_n = LW'(1);
                            dir_n = DIR_LEFT;
                        end else begin
                            lvl_n = lvl - LW'(1);
                        end
                    end
                    pat_n = LED_W'(therm(32'(lvl_n)));
                end
            endcase
        end
    end

    // Pins are registered from the next pattern so led and pat move on the same edge
    always_comb begin
        led_n = pat_n ^ POL;
    end

endmodule

// File: tb/tb_led_flow_multi.sv
// tb/tb_led_flow_multi.sv - directed table-driven bench for led_flow_multi
module tb_led_flow_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed = 2'd0;
    logic       run = 1'b1;
    logic       restart = 1'b0;
    logic [3:0] led;
    logic       step_tick;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    led_flow_multi #(
        .LED_W      (4),
        .CLK_HZ     (1000),
        .STEP_MS    (8),
        .ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .speed     (speed),
        .run       (run),
        .restart   (restart),
        .led       (led),
        .step_tick (step_tick)
    );

    typedef struct {
        logic [1:0] mode;
        logic [1:0] speed;
        logic       run;
        logic       restart;
        int         ncyc;
        logic [3:0] led;
        logic       tick;
        int         nticks;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [1:0] m, input logic [1:0] s, input logic r,
                               input logic rs, input int n, input logic [3:0] l,
                               input logic t, input int nt);
        vec_t x;
        x.mode = m; x.speed = s; x.run = r; x.restart = rs;
        x.ncyc = n; x.led = l; x.tick = t; x.nticks = nt;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled there too
    task automatic apply(input vec_t t, input int idx);
        int nt;
        nt = 0;
        mode = t.mode;
        speed = t.speed;
        run = t.run;
        restart = t.restart;
        for (int c = 0; c < t.ncyc; c++) begin
            @(posedge clk);
            #1;
            restart = 1'b0;
            if (step_tick === 1'b1) nt++;
        end
        check($sformatf("v%0d led", idx), 32'(led), 32'(t.led));
        check($sformatf("v%0d step_tick", idx), 32'(step_tick), 32'(t.tick));
        check($sformatf("v%0d tick_count", idx), nt, t.nticks);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ROL from reset, steps 8 cycles apart
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 8, 4'b1101, 1, 1));
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 8, 4'b1011, 1, 1));
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 8, 4'b0111, 1, 1));
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 8, 4'b1110, 1, 1));
        // ping-pong: reload then 0010 0100 1000 0100 0010 0001 0010
        vecs.push_back(v(2'd2, 2'd0, 1, 0, 1, 4'b1110, 0, 0));
        vecs.push_back(v(2'd2, 2'd0, 1, 0, 8, 4'b1101, 1, 1));
        vecs.push_back(v(2'd2, 2'd0, 1, 0, 8, 4'b1011, 1, 1));
        vecs.push_back(v(2'd2, 2'd0, 1, 0, 8, 4'b0111, 1, 1));
        vecs.push_back(v(2'd2, 2'd0, 1, 0, 8, 4'b1011, 1, 1));
        vecs.push_back(v(2'd2, 2'd0, 1, 0, 8, 4'b1101, 1, 1));
        vecs.push_back(v(2'd2, 2'd0, 1, 0, 8, 4'b1110, 1, 1));
        vecs.push_back(v(2'd2, 2'd0, 1, 0, 8, 4'b1101, 1, 1));
        // bar: 0000 0001 0011 0111 1111 0111 0011 0001 0000 0001
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 1, 4'b1111, 0, 0));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b1110, 1, 1));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b1100, 1, 1));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b1000, 1, 1));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b0000, 1, 1));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b1000, 1, 1));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b1100, 1, 1));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b1110, 1, 1));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b1111, 1, 1));
        vecs.push_back(v(2'd3, 2'd0, 1, 0, 8, 4'b1110, 1, 1));
        // speed change with cnt=5: immediate step, then every 2 cycles
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 1, 4'b1110, 0, 0));
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 5, 4'b1110, 0, 0));
        vecs.push_back(v(2'd0, 2'd2, 1, 0, 1, 4'b1101, 1, 1));
        vecs.push_back(v(2'd0, 2'd2, 1, 0, 2, 4'b1011, 1, 1));
        vecs.push_back(v(2'd0, 2'd2, 1, 0, 2, 4'b0111, 1, 1));
        // pause mid-count (cnt=3) for 20 cycles; resume needs exactly 5 more
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 3, 4'b0111, 0, 0));
        vecs.push_back(v(2'd0, 2'd0, 0, 0, 20, 4'b0111, 0, 0));
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 5, 4'b1110, 1, 1));
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 8, 4'b1101, 1, 1));
        // restart while paused reloads and stays frozen
        vecs.push_back(v(2'd0, 2'd0, 0, 1, 1, 4'b1110, 0, 0));
        vecs.push_back(v(2'd0, 2'd0, 0, 0, 20, 4'b1110, 0, 0));
        // mode 0 -> 1 mid-count: reload to 1000, first step 8 cycles later
        vecs.push_back(v(2'd0, 2'd0, 1, 0, 3, 4'b1110, 0, 0));
        vecs.push_back(v(2'd1, 2'd0, 1, 0, 1, 4'b0111, 0, 0));
        vecs.push_back(v(2'd1, 2'd0, 1, 0, 7, 4'b0111, 0, 0));
        vecs.push_back(v(2'd1, 2'd0, 1, 0, 1, 4'b1011, 1, 1));
        vecs.push_back(v(2'd1, 2'd0, 1, 0, 8, 4'b1101, 1, 1));

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset led", 32'(led), 32'(4'b1110));
        check("reset step_tick", 32'(step_tick), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset led", 32'(led), 32'(4'b1110));
        check("async reset step_tick", 32'(step_tick), 32'd0);
        @(posedge clk);
        #1;
        check("held reset led", 32'(led), 32'(4'b1110));
        rst_n = 1'b1;
        apply(v(2'd0, 2'd0, 1, 0, 8, 4'b1101, 1, 1), 99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
